// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Shared intent codes, requester indices and arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam logic [2:0] INTENT_NONE   = 3'd0;
    localparam logic [2:0] INTENT_DOWN   = 3'd1;
    localparam logic [2:0] INTENT_LEFT   = 3'd2;
    localparam logic [2:0] INTENT_RIGHT  = 3'd3;
    localparam logic [2:0] INTENT_ROTATE = 3'd4;

    localparam logic [1:0] REQ_DOWN   = 2'd0;
    localparam logic [1:0] REQ_LEFT   = 2'd1;
    localparam logic [1:0] REQ_RIGHT  = 2'd2;
    localparam logic [1:0] REQ_ROTATE = 2'd3;
    localparam int         NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_t;

    function automatic logic [2:0] req_to_intent(input logic [1:0] idx);
        logic [2:0] code;
        case (idx)
            REQ_DOWN:   code = INTENT_DOWN;
            REQ_LEFT:   code = INTENT_LEFT;
            REQ_RIGHT:  code = INTENT_RIGHT;
            REQ_ROTATE: code = INTENT_ROTATE;
            default:    code = INTENT_NONE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : 2-flop synchronizer + rising-edge press pulse for one raw button.
//            With TETRIS_AUTO_REPEAT_EN, a held button also auto-repeats.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner
`ifdef TETRIS_AUTO_REPEAT_EN
#(
    parameter int DAS_DELAY     = 4_000_000,
    parameter int REPEAT_PERIOD = 1_500_000,
    parameter bit REPEAT_EN     = 1'b1
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef TETRIS_AUTO_REPEAT_EN
    input  logic restart,
    output logic rise,
`endif
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_prev;

`ifdef TETRIS_AUTO_REPEAT_EN
    logic [31:0] r_das_cnt;
    logic        r_repeating;
    logic        r_rep_pulse;

    // First DAS_DELAY of continuous hold, then one pulse every REPEAT_PERIOD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_das_cnt   <= 32'd0;
            r_repeating <= 1'b0;
            r_rep_pulse <= 1'b0;
        end else begin
            r_rep_pulse <= 1'b0;
            if (!REPEAT_EN || !r_sync2 || restart) begin
                r_das_cnt   <= 32'd0;
                r_repeating <= 1'b0;
            end else if (!r_repeating) begin
                if (r_das_cnt == 32'(DAS_DELAY - 1)) begin
                    r_rep_pulse <= 1'b1;
                    r_repeating <= 1'b1;
                    r_das_cnt   <= 32'd0;
                end else begin
                    r_das_cnt <= r_das_cnt + 32'd1;
                end
            end else if (r_das_cnt == 32'(REPEAT_PERIOD - 1)) begin
                r_rep_pulse <= 1'b1;
                r_das_cnt   <= 32'd0;
            end else begin
                r_das_cnt <= r_das_cnt + 32'd1;
            end
        end
    end

    assign rise  = w_rise;
    assign press = w_rise | r_rep_pulse;
`else
    assign press = w_rise;
`endif

endmodule
`default_nettype wire

// File: rtl/move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : move_arbiter
// Purpose  : Round-robin arbiter of gravity/left/right/rotate moves onto the
//            block memory movement handshake; optional TETRIS_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module move_arbiter
    import tetris_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
`ifdef TETRIS_AUTO_REPEAT_EN
    ,
    parameter int DAS_DELAY      = 4_000_000,
    parameter int REPEAT_PERIOD  = 1_500_000
`endif
)(
    input  logic       clk_25_175,
    input  logic       reset,
    input  logic       enable,
    input  logic       gametick,
    input  logic       buttL,
    input  logic       buttR,
    input  logic       buttT,
    input  logic       mem_busy,
    input  logic       movement_commit,
    input  logic       movement_declined,
    output logic       movement_request,
    output logic [2:0] movement_intent,
    output logic       piece_lock,
    output logic       timeout_err,
    output logic [1:0] grant_id
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            w_press_l;
    logic            w_press_r;
    logic            w_press_t;
    logic [3:0]      w_set;
    logic            w_grant_valid;
    logic [1:0]      w_grant_idx;
    logic [1:0]      w_cand;
    logic [3:0]      w_grant_mask;

    arb_state_t      r_state;
    logic [3:0]      r_pend;
    logic [1:0]      r_ptr;
    logic [TO_W-1:0] r_to_cnt;

`ifdef TETRIS_AUTO_REPEAT_EN
    logic w_rise_l;
    logic w_rise_r;
    logic w_rise_t;
`endif

    btn_conditioner
`ifdef TETRIS_AUTO_REPEAT_EN
        #(.DAS_DELAY(DAS_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
`endif
        u_btn_l (
            .clk     (clk_25_175),
            .rst     (reset),
            .btn     (buttL),
`ifdef TETRIS_AUTO_REPEAT_EN
            .restart (w_rise_r),
            .rise    (w_rise_l),
`endif
            .press   (w_press_l)
        );

    btn_conditioner
`ifdef TETRIS_AUTO_REPEAT_EN
        #(.DAS_DELAY(DAS_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
`endif
        u_btn_r (
            .clk     (clk_25_175),
            .rst     (reset),
            .btn     (buttR),
`ifdef TETRIS_AUTO_REPEAT_EN
            .restart (w_rise_l),
            .rise    (w_rise_r),
`endif
            .press   (w_press_r)
        );

    // Rotate never auto-repeats; its restart input is therefore irrelevant.
    btn_conditioner
`ifdef TETRIS_AUTO_REPEAT_EN
        #(.DAS_DELAY(DAS_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
`endif
        u_btn_t (
            .clk     (clk_25_175),
            .rst     (reset),
            .btn     (buttT),
`ifdef TETRIS_AUTO_REPEAT_EN
            .restart (w_rise_t),
            .rise    (w_rise_t),
`endif
            .press   (w_press_t)
        );

    always_comb begin
        w_set             = 4'b0000;
        w_set[REQ_DOWN]   = gametick;
        w_set[REQ_LEFT]   = w_press_l;
        w_set[REQ_RIGHT]  = w_press_r;
        w_set[REQ_ROTATE] = w_press_t;
    end

    // Scan from the farthest offset back to the pointer so the closest wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = r_ptr;
        w_cand        = r_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = r_ptr + 2'(i);
            if (r_pend[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
        if (r_state != ST_IDLE || !enable || mem_busy) begin
            w_grant_valid = 1'b0;
        end
        w_grant_mask = w_grant_valid ? (4'b0001 << w_grant_idx) : 4'b0000;
    end

    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_pend            <= 4'b0000;
            r_ptr             <= 2'd0;
            r_to_cnt          <= '0;
            movement_request  <= 1'b0;
            movement_intent   <= INTENT_NONE;
            piece_lock        <= 1'b0;
            timeout_err       <= 1'b0;
            grant_id          <= 2'd0;
        end else begin
            piece_lock <= 1'b0;

            // A fresh set beats the grant's clear; a lock drops stale button moves.
            if (!enable) begin
                r_pend <= 4'b0000;
            end else if (r_state == ST_LOCK) begin
                r_pend <= (r_pend | w_set) & (4'b0001 << REQ_DOWN);
            end else begin
                r_pend <= (r_pend & ~w_grant_mask) | w_set;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        movement_request <= 1'b1;
                        movement_intent  <= req_to_intent(w_grant_idx);
                        grant_id         <= w_grant_idx;
                        r_ptr            <= w_grant_idx + 2'd1;
                        r_to_cnt         <= '0;
                        r_state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (movement_declined) begin
                        movement_request <= 1'b0;
                        movement_intent  <= INTENT_NONE;
                        if (movement_intent == INTENT_DOWN) begin
                            piece_lock <= 1'b1;
                            r_state    <= ST_LOCK;
                        end else begin
                            r_state    <= ST_IDLE;
                        end
                    end else if (movement_commit) begin
                        movement_request <= 1'b0;
                        movement_intent  <= INTENT_NONE;
                        r_state          <= ST_IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        movement_request <= 1'b0;
                        movement_intent  <= INTENT_NONE;
                        timeout_err      <= 1'b1;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_LOCK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Sequences every piece-movement transaction into the block memory's movement handshake (request/intent, then commit/declined).
- Shares that single path between four requesters: gravity (gametick), left, right and rotate buttons.
- Round-robin arbitration, one transaction outstanding at a time.
- A declined gravity move is turned into a one-cycle piece-lock pulse for the cell storage.
- Sits between the timer/buttons and the block memory, in the clk_25_175 domain.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles WAIT tolerates with no commit/declined before aborting.
- DAS_DELAY, 4_000_000: cycles a held left/right button must stay held before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 1_500_000: cycles between auto-repeat requests (AUTO_REPEAT_EN only).

Ports:
- clk_25_175  in  1  system pixel clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running; when low, no new grants and pending flags are cleared.
- gametick  in  1  one-cycle gravity pulse, same clock domain.
- buttL  in  1  raw left button, async, active-high.
- buttR  in  1  raw right button, async, active-high.
- buttT  in  1  raw rotate button, async, active-high.
- mem_busy  in  1  block memory busy (VGA read); new grants are blocked while high.
- movement_commit  in  1  one-cycle pulse: move accepted.
- movement_declined  in  1  one-cycle pulse: move rejected.
- movement_request  out  1  held high for the whole transaction.
- movement_intent  out  3  intent code, stable while movement_request is high.
- piece_lock  out  1  one-cycle pulse after a declined gravity move.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.
- grant_id  out  2  last granted requester (0 down, 1 left, 2 right, 3 rotate).

Behaviour:
- Reset (asynchronous, any cycle, including mid-transaction):
  - state=IDLE, movement_request=0, movement_intent=0, piece_lock=0, timeout_err=0, grant_id=0.
  - Pending flags clear; round-robin pointer=0; synchronizers clear.
- Input conditioning:
  - Each button goes through a 2-flop synchronizer, then rising-edge detection.
  - A button edge at cycle n sets its pending flag at n+3.
  - gametick sets pending_down at n+1.
- Pending flags:
  - A set while already set coalesces (no count).
  - A set in the same cycle as the grant that clears the flag wins: the flag stays 1.
- IDLE:
  - Condition to grant: enable=1, mem_busy=0 and any pending flag set.
  - Round-robin pick from pointer order down, left, right, rotate.
  - Next cycle: movement_request=1, movement_intent=code, grant_id updated, winner's flag cleared, pointer moves to winner+1 mod 4, state=WAIT.
  - Latency: pending set at cycle k gives request high at k+1 with an idle arbiter.
- WAIT:
  - movement_request held high; timeout counter counts cycles in WAIT.
  - movement_commit → request low next cycle → IDLE.
  - movement_declined → request low next cycle. If the intent was DOWN, go to LOCK; otherwise go to IDLE.
  - commit and declined in the same cycle → treated as declined.
  - Counter reaches TIMEOUT_CYCLES → request low, timeout_err=1, IDLE; the move is dropped.
  - mem_busy is ignored in WAIT.
- LOCK:
  - piece_lock=1 for exactly one cycle.
  - Clear pending left/right/rotate (stale input against the old piece); pending_down is kept.
  - → IDLE.
- enable falling in WAIT: the transaction completes normally; IDLE then holds.
- Commit/declined pulses arriving in IDLE or LOCK are ignored.
- Intent codes: 0 NONE, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ROTATE. The intent output is 0 whenever movement_request=0.

Optional Feature:
- TETRIS_AUTO_REPEAT_EN defined:
  - A left or right button held continuously (synchronized level) for DAS_DELAY cycles sets its pending flag.
  - It then sets the flag again every REPEAT_PERIOD cycles while held.
  - Release resets that button's DAS counter.
  - Pressing the opposite direction restarts both counters.
- Not defined: only rising edges set the flags; the counters are absent.

Decomposition:
- Shared package tetris_pkg:
  - intent code constants (INTENT_NONE..INTENT_ROTATE).
  - requester index constants.
  - the arbiter state encoding.
- One sub-module btn_conditioner: synchronizer plus edge detect, and the DAS counter when the macro is defined. Instantiated three times.

Test Plan:
- Left edge at cycle 10, mem idle → movement_request=1 and intent=2 at cycle 14; commit at 20 → request=0 at 21.
- gametick and rotate pending together with pointer=0 → DOWN granted first, then ROTATE; grant_id sequence 0, 3.
- Gravity declined → piece_lock high exactly one cycle; a pending left set beforehand is cleared and no LEFT request follows.
- No response for 1024 cycles in WAIT → request drops, timeout_err=1 and stays 1 across later commits.
- mem_busy=1 for 50 cycles with left pending → no request until mem_busy=0, then request the next cycle.
- Reset asserted mid-WAIT → movement_request=0 and all outputs 0 immediately, without a clock edge.
